// File: rtl/seg_hex_display.sv
// Multi-digit hex seven-segment driver: captured attributes, decimal points,
// blanking, leading-zero suppression and a timed per-digit blink.
module seg_hex_display #(
  parameter int unsigned DIGITS     = 8,
  parameter int unsigned BLINK_DIV  = 25_000_000,
  parameter bit          ACTIVE_LOW = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   din,
  input  logic [DIGITS-1:0]     dp_mask,
  input  logic [DIGITS-1:0]     blank_mask,
  input  logic [DIGITS-1:0]     blink_mask,
  input  logic                  lz_en,
  output logic [8*DIGITS-1:0]   segs
);

  localparam int unsigned    CW       = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [CW-1:0]  CNT_LAST = CW'(BLINK_DIV - 1);
  localparam logic [7:0]     OFF_BYTE = ACTIVE_LOW ? 8'hFF : 8'h00;

  logic [4*DIGITS-1:0] r_data;
  logic [DIGITS-1:0]   r_dp;
  logic [DIGITS-1:0]   r_blank;
  logic [DIGITS-1:0]   r_blink;
  logic                r_lz;
  logic [CW-1:0]       r_cnt;
  logic                r_phase;
  logic [8*DIGITS-1:0] r_segs;

  logic [8*DIGITS-1:0] w_segs_next;
  logic [7:0]          w_byte;
  logic                w_off;

  function automatic logic [7:0] hex_decode(input logic [3:0] nib);
    logic [7:0] code;
    unique case (nib)
      4'h0: code = 8'h03;
      4'h1: code = 8'h9F;
      4'h2: code = 8'h25;
      4'h3: code = 8'h0D;
      4'h4: code = 8'h99;
      4'h5: code = 8'h49;
      4'h6: code = 8'h41;
      4'h7: code = 8'h1F;
      4'h8: code = 8'h01;
      4'h9: code = 8'h09;
      4'hA: code = 8'h11;
      4'hB: code = 8'hC1;
      4'hC: code = 8'h63;
      4'hD: code = 8'h85;
      4'hE: code = 8'h61;
      default: code = 8'h71;
    endcase
    return code;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      r_data  <= '0;
      r_dp    <= '0;
      r_blank <= '1;
      r_blink <= '0;
      r_lz    <= 1'b0;
    end else if (load) begin
      r_data  <= din;
      r_dp    <= dp_mask;
      r_blank <= blank_mask;
      r_blink <= blink_mask;
      r_lz    <= lz_en;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt   <= '0;
      r_phase <= 1'b0;
    end else if (r_cnt == CNT_LAST) begin
      r_cnt   <= '0;
      r_phase <= ~r_phase;
    end else begin
      r_cnt   <= r_cnt + 1'b1;
    end
  end

  // A digit is zero-suppressed when it and every more significant nibble are zero.
  always_comb begin
    w_segs_next = '0;
    w_byte      = '0;
    w_off       = 1'b0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      w_byte = hex_decode(r_data[4*i +: 4]);
      if (r_dp[i]) begin
        w_byte[0] = 1'b0;
      end
      w_off = r_blank[i]
            | (r_blink[i] & r_phase)
            | (r_lz && (i != 0) && ((r_data >> (4*i)) == '0));
      if (w_off) begin
        w_byte = 8'hFF;
      end
      if (!ACTIVE_LOW) begin
        w_byte = ~w_byte;
      end
      w_segs_next[8*i +: 8] = w_byte;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_segs <= {DIGITS{OFF_BYTE}};
    end else begin
      r_segs <= w_segs_next;
    end
  end

  assign segs = r_segs;

endmodule

// File: tb/tb_seg_hex_display.sv
// Directed scoreboard bench: stimulus queues expected segment words per cycle,
// a negedge monitor pops and compares them against two polarity builds.
module tb_seg_hex_display;

  logic        clk = 1'b0;
  logic        rst;
  logic        load;
  logic [15:0] din;
  logic [3:0]  dp_mask;
  logic [3:0]  blank_mask;
  logic [3:0]  blink_mask;
  logic        lz_en;
  logic [31:0] segs_a;
  logic [31:0] segs_b;

  seg_hex_display #(.DIGITS(4), .BLINK_DIV(4), .ACTIVE_LOW(1'b1)) u_dut_a (
    .clk(clk), .rst(rst), .load(load), .din(din), .dp_mask(dp_mask),
    .blank_mask(blank_mask), .blink_mask(blink_mask), .lz_en(lz_en), .segs(segs_a)
  );

  seg_hex_display #(.DIGITS(4), .BLINK_DIV(4), .ACTIVE_LOW(1'b0)) u_dut_b (
    .clk(clk), .rst(rst), .load(load), .din(din), .dp_mask(dp_mask),
    .blank_mask(blank_mask), .blink_mask(blink_mask), .lz_en(lz_en), .segs(segs_b)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    bit          dut_b;
    logic [31:0] exp;
    string       name;
  } exp_t;

  exp_t sbq[$];
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_err = 0;
  int   rst_edge = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every negedge, compare each entry due this cycle.
  exp_t        m_e;
  logic [31:0] m_act;
  always @(negedge clk) begin
    while (sbq.size() > 0 && sbq[0].cyc <= cyc) begin
      m_e   = sbq.pop_front();
      m_act = m_e.dut_b ? segs_b : segs_a;
      n_cmp++;
      if (m_e.cyc != cyc || m_act !== m_e.exp) begin
        n_err++;
        $display("FAIL %s (cyc %0d, due %0d): segs=%h expected=%h",
                 m_e.name, cyc, m_e.cyc, m_act, m_e.exp);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int c, input bit b, input logic [31:0] v, input string nm);
    exp_t e;
    e.cyc = c; e.dut_b = b; e.exp = v; e.name = nm;
    sbq.push_back(e);
  endtask

  task automatic do_load(input logic [15:0] d, input logic [3:0] dpm, input logic [3:0] bm,
                         input logic [3:0] blm, input logic lz, input logic [31:0] ea,
                         input bit chk_b, input logic [31:0] eb, input string nm);
    din = d; dp_mask = dpm; blank_mask = bm; blink_mask = blm; lz_en = lz; load = 1'b1;
    push(cyc + 2, 1'b0, ea, nm);
    if (chk_b) push(cyc + 2, 1'b1, eb, {nm, "_pol"});
    tick();
    load = 1'b0;
    tick();
  endtask

  // Blink phase seen in segs after edge m, derived from the last reset edge.
  function automatic bit dark_at(input int m);
    return (((m - 1 - rst_edge) / 4) % 2) == 1;
  endfunction

  int guard;

  initial begin
    rst = 1'b1; load = 1'b1; din = 16'h1234;
    dp_mask = '0; blank_mask = '0; blink_mask = '0; lz_en = 1'b0;

    push(1, 1'b0, 32'hFFFF_FFFF, "reset_hold1");
    push(2, 1'b0, 32'hFFFF_FFFF, "reset_hold2");
    push(3, 1'b0, 32'hFFFF_FFFF, "reset_release");
    push(3, 1'b1, 32'h0000_0000, "reset_release_pol");
    tick(); tick();
    rst = 1'b0; load = 1'b0; rst_edge = 2;
    tick();

    do_load(16'hA5C0, 4'h0, 4'h0, 4'h0, 1'b0, 32'h1149_6303, 1'b0, '0, "basic_load");

    din = 16'hFFFF; dp_mask = '1; blank_mask = '1; blink_mask = '1; lz_en = 1'b1;
    repeat (3) tick();
    push(cyc, 1'b0, 32'h1149_6303, "hold_no_load");

    // Back-to-back loads with load held: each tracked, last wins.
    din = 16'h1234; dp_mask = '0; blank_mask = '0; blink_mask = '0; lz_en = 1'b0; load = 1'b1;
    push(cyc + 2, 1'b0, 32'h9F25_0D99, "b2b_first");
    tick();
    din = 16'h5678;
    push(cyc + 2, 1'b0, 32'h4941_1F01, "b2b_last");
    tick();
    load = 1'b0;
    tick(); tick();
    push(cyc, 1'b0, 32'h4941_1F01, "b2b_hold");
    tick();

    do_load(16'h0070, 4'h8, 4'h0, 4'h0, 1'b1, 32'hFFFF_1F03, 1'b0, '0, "lz_0070");
    do_load(16'h0000, 4'h8, 4'h0, 4'h0, 1'b1, 32'hFFFF_FF03, 1'b0, '0, "lz_0000");
    do_load(16'h8888, 4'h5, 4'h2, 4'h0, 1'b0, 32'h0100_FF00, 1'b0, '0, "dp_blank");

    din = 16'h1111; dp_mask = '0; blank_mask = '0; blink_mask = 4'h1; lz_en = 1'b0; load = 1'b1;
    tick();
    load = 1'b0;
    for (int k = 0; k < 16; k++) begin
      tick();
      push(cyc, 1'b0, {24'h9F9F9F, dark_at(cyc) ? 8'hFF : 8'h9F}, "blink");
    end

    guard = 0;
    while (!dark_at(cyc) && guard < 10) begin
      tick();
      guard++;
    end
    if (!dark_at(cyc)) begin
      n_cmp++; n_err++;
      $display("FAIL find_dark_phase: no dark phase within 10 cycles (cyc %0d)", cyc);
    end
    rst = 1'b1;
    push(cyc + 1, 1'b0, 32'hFFFF_FFFF, "rst_in_dark");
    tick();
    rst = 1'b0; rst_edge = cyc; load = 1'b1;
    push(cyc + 1, 1'b0, 32'hFFFF_FFFF, "post_rst_blank");
    tick();
    load = 1'b0;
    for (int k = 0; k < 12; k++) begin
      tick();
      push(cyc, 1'b0, {24'h9F9F9F, dark_at(cyc) ? 8'hFF : 8'h9F}, "blink_restart");
    end

    blink_mask = '0;
    rst = 1'b1;
    push(cyc + 1, 1'b0, 32'hFFFF_FFFF, "pol_reset_a");
    push(cyc + 1, 1'b1, 32'h0000_0000, "pol_reset_b");
    tick();
    rst = 1'b0;
    tick();
    do_load(16'h0003, 4'h0, 4'h0, 4'h0, 1'b0, 32'h0303_030D, 1'b1, 32'hFCFC_FCF2, "pol_0003");

    guard = 0;
    while (sbq.size() > 0 && guard < 20) begin
      @(negedge clk);
      #1;
      guard++;
    end
    while (sbq.size() > 0) begin
      m_e = sbq.pop_front();
      n_cmp++; n_err++;
      $display("FAIL %s: check never reached (due cyc %0d), expected=%h", m_e.name, m_e.cyc, m_e.exp);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/seg_hex_display.md
# seg_hex_display

Parametrised multi-digit hexadecimal seven-segment display driver for the NVBoard digit-test designs. It takes a packed nibble vector plus per-digit attributes, captures them on a load strobe, and drives one static 8-bit segment byte per digit. Added features are decimal points, per-digit blanking, leading-zero suppression and a timed per-digit blink. It sits between application logic (key scanner, counters, CPU MMIO) and the board's segment pins, and supersedes the fixed two-digit combinational decoder.

## Interface
- `DIGITS`, 8: number of digits, legal range 1..8.
- `BLINK_DIV`, 25_000_000: clock cycles per blink half-period, minimum 2.
- `ACTIVE_LOW`, 1: 1 means segment lit = 0 (common anode); 0 means the whole output byte is inverted.
- `clk`, input, 1: sole clock, rising edge.
- `rst`, input, 1: reset; one clock; reset is synchronous and active-high.
- `load`, input, 1: capture strobe for all attribute inputs below.
- `din`, input, 4*DIGITS: nibble i = `din[4i+3:4i]` is digit i; digit 0 is least significant.
- `dp_mask`, input, DIGITS: bit i lights the decimal point of digit i.
- `blank_mask`, input, DIGITS: bit i forces digit i fully off, including its decimal point.
- `blink_mask`, input, DIGITS: bit i makes digit i blink.
- `lz_en`, input, 1: enables leading-zero suppression.
- `segs`, output, 8*DIGITS: byte i = `segs[8i+7:8i]` drives digit i, bit order a,b,c,d,e,f,g,dp (bit7..bit0); registered.

## Operation
- **Capture registers:** `data_q`, `dp_q`, `blank_q`, `blink_q`, `lz_q`.
  - On a cycle with `load`=1, all five load from their inputs. Otherwise they hold.
  - Inputs are ignored while `load`=0.
- **Blink timer:**
  - Free-running counter `cnt` counts 0..BLINK_DIV-1 and wraps to 0.
  - At each wrap, `phase` toggles.
  - The timer runs regardless of `load`.
- **Per-digit decode** (active-low form, ACTIVE_LOW=1):
  - 0=03, 1=9F, 2=25, 3=0D, 4=99, 5=49, 6=41, 7=1F, 8=01, 9=09, A=11, b=C1, C=63, d=85, E=61, F=71 (hex).
  - If `dp_q[i]`=1, bit0 is cleared (lit).
- **Digit off condition:** digit i is off (byte = FF) if any of the following holds:
  - `blank_q[i]`=1.
  - `blink_q[i]`=1 and `phase`=1.
  - `lz_q`=1, i≠0, and nibbles i..DIGITS-1 of `data_q` are all zero. A suppressed digit also loses its decimal point.
  - Digit 0 is never zero-suppressed.
- **Priority:** off condition > decode.
- **Output polarity:** ACTIVE_LOW=0 inverts every byte after all of the above, so off = 00.
- **Output register:** `segs` is updated every cycle from the capture registers and `phase`.

## Timing
- **Reset** (`rst`=1 at a rising edge):
  - `data_q`=0, `dp_q`=0, `blink_q`=0, `lz_q`=0.
  - `blank_q`=all ones.
  - `cnt`=0, `phase`=0.
  - `segs`=FF per byte (00 per byte when ACTIVE_LOW=0).
  - The display stays dark until the first load.
- **Reset priority:** `rst` overrides a simultaneous `load`. Reset mid-blink restarts the timer at `cnt`=0, `phase`=0.
- **Load latency:** `load` sampled at edge k updates the capture registers at edge k; `segs` shows the new content after edge k+1 (2-edge latency).
- **Back-to-back loads:** each is captured; the last one wins. Holding `load` high tracks the inputs with the same 2-edge latency.
- **Blink period:** `phase` toggles at the edge where `cnt` goes BLINK_DIV-1 to 0, i.e. every BLINK_DIV cycles. A blinking digit is visible for BLINK_DIV cycles, then dark for BLINK_DIV cycles, with `segs` lagging `phase` by one edge. The first toggle occurs BLINK_DIV edges after reset release.
- **Load during a blink phase:** a load coinciding with a phase toggle applies both; the timer is not restarted by `load`.
- **Widths:** `cnt` is $clog2(BLINK_DIV) bits. No arithmetic wider than that.

## Test plan
Bench parameters: DIGITS=4, BLINK_DIV=4, ACTIVE_LOW=1.
- **Reset:** hold `rst` 2 cycles with `load`=1, `din`=1234 → `segs`=FFFFFFFF throughout and one edge after release.
- **Basic load:** load `din`=A5C0, masks 0, `lz_en`=0 → two edges later `segs`=11_49_63_03 (digit3..digit0). Inputs changed while `load`=0 do not alter `segs`.
- **Leading-zero suppression:** load `din`=0070, `lz_en`=1, `dp_mask`=1000 → `segs`=FF_FF_1F_03 (digit3 decimal point dropped by suppression). Then load `din`=0000 → FF_FF_FF_03.
- **Decimal point and blank:** load `din`=8888, `dp_mask`=0101, `blank_mask`=0010 → `segs`=01_00_FF_00.
- **Blink:** load `din`=1111, `blink_mask`=0001 → digit0 alternates 9F for 4 cycles / FF for 4 cycles while digits 1..3 stay 9F. Assert `rst` during a dark phase → next edge all FF, blink phase restarts at 0.
- **Polarity:** rebuild with ACTIVE_LOW=0 and load `din`=0003 → `segs`=FC_FC_FC_F2. After reset, `segs`=00000000.
